// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types for the SDRAM port arbiter: controller command codes, FSM states
// and a constant-evaluable ceil(log2) helper.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_WR,
        ST_WAIT_RD,
        ST_GAP
    } state_e;

    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_select.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping
// modulo N. Returns a one-hot grant, its index and an any-request flag.
module rr_select #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int               slot;
    logic [IDX_W-1:0] slot_idx;

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        idx      = '0;
        any      = 1'b0;
        slot     = 0;
        slot_idx = '0;
        for (int off = N - 1; off >= 0; off--) begin
            slot = int'(ptr) + off;
            if (slot >= N) begin
                slot = slot - N;
            end
            slot_idx = IDX_W'(slot);
            if (req[slot_idx]) begin
                idx = slot_idx;
                any = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_gnt
        assign gnt[gi] = any && (idx == IDX_W'(gi));
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Multi-port round-robin front end for the SDRAM controller command port.
// Optional build macro SDRAM_ARB_PORT0_PRIO_EN gives port 0 absolute priority.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 32,
    parameter int READ_BURST = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        port_req,
    input  logic [NUM_PORTS-1:0]        port_we,
    input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] port_wdata,
    output logic [NUM_PORTS-1:0]        port_gnt,
    output logic [DATA_W-1:0]           port_rdata,
    output logic [NUM_PORTS-1:0]        port_rvalid,
    output logic [NUM_PORTS-1:0]        port_wdone,
    output logic [1:0]                  ctl_command,
    output logic [ADDR_W-1:0]           ctl_addr,
    output logic [DATA_W-1:0]           ctl_wdata,
    input  logic [DATA_W-1:0]           ctl_rdata,
    input  logic                        ctl_rvalid,
    input  logic                        ctl_wdone
);

    localparam int IDX_W  = clog2_f(NUM_PORTS);
    localparam int BEAT_W = clog2_f(READ_BURST) + 1;

    state_e                 state_reg;
    cmd_e                   ctl_command_reg;
    logic [ADDR_W-1:0]      ctl_addr_reg;
    logic [DATA_W-1:0]      ctl_wdata_reg;
    logic [NUM_PORTS-1:0]   port_gnt_reg;
    logic [IDX_W-1:0]       rr_ptr_reg;
    logic [IDX_W-1:0]       owner_reg;
    logic                   owner_valid_reg;
    logic                   is_read_reg;
    logic [BEAT_W-1:0]      beat_cnt_reg;

    logic [NUM_PORTS-1:0]   rr_req;
    logic [NUM_PORTS-1:0]   rr_gnt;
    logic [IDX_W-1:0]       rr_idx;
    logic                   rr_any;
    logic [NUM_PORTS-1:0]   win_onehot;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_any;
    logic [IDX_W-1:0]       ptr_next;
    logic                   in_rd_phase;
    logic                   in_wr_phase;
    logic                   rd_accept;
    logic                   wr_accept;

`ifdef SDRAM_ARB_PORT0_PRIO_EN
    assign rr_req = {port_req[NUM_PORTS-1:1], 1'b0};
`else
    assign rr_req = port_req;
`endif

    rr_select #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req (rr_req),
        .ptr (rr_ptr_reg),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    always_comb begin
        win_onehot = rr_gnt;
        win_idx    = rr_idx;
        win_any    = rr_any;
`ifdef SDRAM_ARB_PORT0_PRIO_EN
        if (port_req[0]) begin
            win_onehot = NUM_PORTS'(1);
            win_idx    = '0;
            win_any    = 1'b1;
        end
`endif
    end

    always_comb begin
        ptr_next = (owner_reg == IDX_W'(NUM_PORTS - 1)) ? '0 : owner_reg + 1'b1;
`ifdef SDRAM_ARB_PORT0_PRIO_EN
        // Port 0 grants leave the rotation untouched; the rotation never lands on port 0.
        if (owner_reg == '0) begin
            ptr_next = rr_ptr_reg;
        end else if (ptr_next == '0) begin
            ptr_next = IDX_W'(1);
        end
`endif
    end

    // Completions count only while the matching transaction type is outstanding.
    assign in_rd_phase = owner_valid_reg && is_read_reg &&
                         (state_reg == ST_ISSUE || state_reg == ST_WAIT_RD);
    assign in_wr_phase = owner_valid_reg && !is_read_reg &&
                         (state_reg == ST_ISSUE || state_reg == ST_WAIT_WR);
    assign rd_accept   = ctl_rvalid && in_rd_phase;
    assign wr_accept   = ctl_wdone && in_wr_phase;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
        assign port_rvalid[gi] = rd_accept && (owner_reg == IDX_W'(gi));
        assign port_wdone[gi]  = wr_accept && (owner_reg == IDX_W'(gi));
    end

    assign port_rdata  = ctl_rdata;
    assign port_gnt    = port_gnt_reg;
    assign ctl_command = ctl_command_reg;
    assign ctl_addr    = ctl_addr_reg;
    assign ctl_wdata   = ctl_wdata_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            ctl_command_reg <= CMD_NOP;
            ctl_addr_reg    <= '0;
            ctl_wdata_reg   <= '0;
            port_gnt_reg    <= '0;
            rr_ptr_reg      <= '0;
            owner_reg       <= '0;
            owner_valid_reg <= 1'b0;
            is_read_reg     <= 1'b0;
            beat_cnt_reg    <= '0;
        end else begin
            port_gnt_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (win_any) begin
                        owner_reg       <= win_idx;
                        owner_valid_reg <= 1'b1;
                        is_read_reg     <= !port_we[win_idx];
                        ctl_command_reg <= port_we[win_idx] ? CMD_WRITE : CMD_READ;
                        ctl_addr_reg    <= port_addr[win_idx*ADDR_W +: ADDR_W];
                        ctl_wdata_reg   <= port_wdata[win_idx*DATA_W +: DATA_W];
                        port_gnt_reg    <= win_onehot;
                        beat_cnt_reg    <= '0;
                        state_reg       <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_WAIT_RD, ST_WAIT_WR: begin
                    if (rd_accept) begin
                        ctl_command_reg <= CMD_NOP;
                        beat_cnt_reg    <= beat_cnt_reg + 1'b1;
                        state_reg       <= (beat_cnt_reg == BEAT_W'(READ_BURST - 1)) ?
                                           ST_GAP : ST_WAIT_RD;
                    end else if (wr_accept) begin
                        ctl_command_reg <= CMD_NOP;
                        state_reg       <= ST_GAP;
                    end else if (state_reg == ST_ISSUE) begin
                        state_reg <= is_read_reg ? ST_WAIT_RD : ST_WAIT_WR;
                    end
                end
                ST_GAP: begin
                    rr_ptr_reg      <= ptr_next;
                    owner_valid_reg <= 1'b0;
                    state_reg       <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef SIM
    logic stray_event_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stray_event_reg <= 1'b0;
        end else if ((ctl_rvalid && !in_rd_phase) || (ctl_wdone && !in_wr_phase)) begin
            stray_event_reg <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a behavioural controller model and
// an in-order scoreboard of expected grants and completions.
module tb_sdram_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 22;
    localparam int DW = 32;
    localparam int RB = 4;
    localparam logic [AW-1:0] AMASK = {AW{1'b1}};

    typedef struct {
        int          port;
        bit          is_wr;
        logic [31:0] data;
    } resp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NP-1:0]     port_req = '0;
    logic [NP-1:0]     port_we = '0;
    logic [NP*AW-1:0]  port_addr = '0;
    logic [NP*DW-1:0]  port_wdata = '0;
    logic [NP-1:0]     port_gnt;
    logic [DW-1:0]     port_rdata;
    logic [NP-1:0]     port_rvalid;
    logic [NP-1:0]     port_wdone;
    logic [1:0]        ctl_command;
    logic [AW-1:0]     ctl_addr;
    logic [DW-1:0]     ctl_wdata;
    logic [DW-1:0]     ctl_rdata = '0;
    logic              ctl_rvalid = 1'b0;
    logic              ctl_wdone = 1'b0;

    int checks = 0;
    int errors = 0;
    int rv_seen = 0;
    int rem_cnt [NP];
    resp_t resp_q [$];
    int    gnt_q  [$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] mdl_mem [logic [AW-1:0]];

    sdram_port_arbiter #(
        .NUM_PORTS  (NP),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .READ_BURST (RB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .port_req    (port_req),
        .port_we     (port_we),
        .port_addr   (port_addr),
        .port_wdata  (port_wdata),
        .port_gnt    (port_gnt),
        .port_rdata  (port_rdata),
        .port_rvalid (port_rvalid),
        .port_wdone  (port_wdone),
        .ctl_command (ctl_command),
        .ctl_addr    (ctl_addr),
        .ctl_wdata   (ctl_wdata),
        .ctl_rdata   (ctl_rdata),
        .ctl_rvalid  (ctl_rvalid),
        .ctl_wdone   (ctl_wdone)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] default_word(input logic [AW-1:0] a);
        return {10'h0, a} ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard entries in the order the arbiter is expected to serve them.
    task automatic expect_txn(input int p, input bit we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data);
        resp_t r;
        logic [AW-1:0] a;
        gnt_q.push_back(p);
        if (we) begin
            r.port = p; r.is_wr = 1'b1; r.data = '0;
            resp_q.push_back(r);
            ref_mem[addr] = data;
        end else begin
            for (int b = 0; b < RB; b++) begin
                a = (addr + AW'(b)) & AMASK;
                r.port = p; r.is_wr = 1'b0;
                r.data = ref_mem.exists(a) ? ref_mem[a] : default_word(a);
                resp_q.push_back(r);
            end
        end
    endtask

    task automatic set_port(input int p, input bit we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input int cnt);
        port_we[p]            = we;
        port_addr[p*AW +: AW] = addr;
        port_wdata[p*DW +: DW] = data;
        rem_cnt[p]            = cnt;
        port_req[p]           = 1'b1;
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n;
        bit quiet;
        n = 0;
        quiet = (resp_q.size() == 0) && (gnt_q.size() == 0) && (port_req == '0);
        while (!quiet && n < budget) begin
            @(posedge clk); #2;
            n++;
            quiet = (resp_q.size() == 0) && (gnt_q.size() == 0) && (port_req == '0);
        end
        check({tag, "_completed"}, 64'(quiet), 64'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    // Controller model: latches a command once, answers after a short delay,
    // and only accepts a new command after seeing NOP.
    bit            m_busy = 1'b0;
    bit            m_armed = 1'b1;
    bit            m_is_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    int            m_delay = 0;
    int            m_beat = 0;

    always @(posedge clk) begin
        logic [AW-1:0] a;
        #1;
        ctl_rvalid = 1'b0;
        ctl_wdone  = 1'b0;
        ctl_rdata  = '0;
        if (m_busy) begin
            if (m_delay != 0) begin
                m_delay--;
            end else if (m_is_wr) begin
                ctl_wdone = 1'b1;
                mdl_mem[m_addr] = m_data;
                m_busy = 1'b0;
            end else begin
                a = (m_addr + AW'(m_beat)) & AMASK;
                ctl_rvalid = 1'b1;
                ctl_rdata  = mdl_mem.exists(a) ? mdl_mem[a] : default_word(a);
                m_beat++;
                if (m_beat == RB) m_busy = 1'b0;
            end
        end else if (m_armed && ctl_command != 2'd0) begin
            m_busy  = 1'b1;
            m_armed = 1'b0;
            m_is_wr = (ctl_command == 2'd1);
            m_addr  = ctl_addr;
            m_data  = ctl_wdata;
            m_delay = 2;
            m_beat  = 0;
        end
        if (ctl_command == 2'd0) m_armed = 1'b1;
    end

    // Output monitor: compares grants and completions against the scoreboard.
    always @(negedge clk) begin
        resp_t r;
        int e;
        if (port_gnt != '0) begin
            if (gnt_q.size() == 0) begin
                check("gnt_unexpected", 64'(port_gnt), 64'd0);
            end else begin
                e = gnt_q.pop_front();
                check("gnt_port", 64'(port_gnt), 64'(1 << e));
                $display("grant: port_gnt=%b expected port %0d", port_gnt, e);
            end
            for (int p = 0; p < NP; p++) begin
                if (port_gnt[p] && rem_cnt[p] > 0) begin
                    rem_cnt[p]--;
                    if (rem_cnt[p] == 0) port_req[p] = 1'b0;
                end
            end
        end
        if (port_rvalid != '0 || port_wdone != '0) begin
            if (resp_q.size() == 0) begin
                check("resp_unexpected", 64'({port_rvalid, port_wdone}), 64'd0);
            end else begin
                r = resp_q.pop_front();
                if (r.is_wr) begin
                    check("wdone_port", 64'({port_rvalid, port_wdone}), 64'(1 << r.port));
                    $display("wdone: port_wdone=%b expected port %0d", port_wdone, r.port);
                end else begin
                    check("rvalid_port", 64'({port_rvalid, port_wdone}), 64'(1 << (r.port + NP)));
                    check("rdata", 64'(port_rdata), 64'(r.data));
                    $display("rbeat: port_rvalid=%b rdata=0x%08h expected port %0d data 0x%08h",
                             port_rvalid, port_rdata, r.port, r.data);
                    rv_seen++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int p = 0; p < NP; p++) rem_cnt[p] = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 64'(port_gnt), 64'd0);
        check("rst_rvalid", 64'(port_rvalid), 64'd0);
        check("rst_wdone", 64'(port_wdone), 64'd0);
        check("rst_cmd", 64'(ctl_command), 64'd0);
        check("rst_addr", 64'(ctl_addr), 64'd0);
        check("rst_wdata", 64'(ctl_wdata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single 4-beat read on port 2
        expect_txn(2, 1'b0, 22'h00123, 32'h0);
        set_port(2, 1'b0, 22'h00123, 32'h0, 1);
        @(posedge clk); #1;
        check("t1_cmd_read", 64'(ctl_command), 64'd2);
        check("t1_addr", 64'(ctl_addr), 64'h00123);
        check("t1_gnt", 64'(port_gnt), 64'b0100);
        wait_quiet("t1", 200);
        check("t1_cmd_nop", 64'(ctl_command), 64'd0);

        // 4: pointer now 3; ports 1 and 3 request together
        expect_txn(3, 1'b0, 22'h00040, 32'h0);
        expect_txn(1, 1'b0, 22'h00080, 32'h0);
        set_port(1, 1'b0, 22'h00080, 32'h0, 1);
        set_port(3, 1'b0, 22'h00040, 32'h0, 1);
        wait_quiet("t4", 400);

        // 2: write then read back on port 1 at the top address
        expect_txn(1, 1'b1, 22'h3FFFFF, 32'hDEADBEEF);
        set_port(1, 1'b1, 22'h3FFFFF, 32'hDEADBEEF, 1);
        @(posedge clk); #1;
        check("t2_cmd_write", 64'(ctl_command), 64'd1);
        check("t2_addr", 64'(ctl_addr), 64'h3FFFFF);
        check("t2_wdata", 64'(ctl_wdata), 64'hDEADBEEF);
        wait_quiet("t2w", 200);
        expect_txn(1, 1'b0, 22'h3FFFFF, 32'h0);
        set_port(1, 1'b0, 22'h3FFFFF, 32'h0, 1);
        wait_quiet("t2r", 200);

        // 5: reset during a read after beat 2 of 4
        rv_seen = 0;
        expect_txn(0, 1'b0, 22'h00200, 32'h0);
        set_port(0, 1'b0, 22'h00200, 32'h12345678, 1);
        n = 0;
        while (rv_seen < 2 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        check("t5_two_beats", 64'(rv_seen), 64'd2);
        resp_q.delete();
        rst_n = 1'b0;
        #1;
        check("t5_rst_rvalid", 64'(port_rvalid), 64'd0);
        check("t5_rst_gnt", 64'(port_gnt), 64'd0);
        check("t5_rst_cmd", 64'(ctl_command), 64'd0);
        check("t5_rst_addr", 64'(ctl_addr), 64'd0);
        check("t5_rst_wdata", 64'(ctl_wdata), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        expect_txn(3, 1'b0, 22'h00300, 32'h0);
        set_port(3, 1'b0, 22'h00300, 32'h0, 1);
        wait_quiet("t5_after", 200);

`ifndef SDRAM_ARB_PORT0_PRIO_EN
        // 3: all ports request continuously for 8 transactions
        for (int rep = 0; rep < 2; rep++) begin
            for (int p = 0; p < NP; p++) begin
                expect_txn(p, 1'b0, AW'(22'h01000 + p * 16), 32'h0);
            end
        end
        for (int p = 0; p < NP; p++) begin
            set_port(p, 1'b0, AW'(22'h01000 + p * 16), 32'h0, 2);
        end
        wait_quiet("t3", 2000);
`else
        // 6: port 0 priority over continuous port 2 requests
        for (int k = 0; k < 3; k++) expect_txn(0, 1'b0, 22'h02000, 32'h0);
        expect_txn(2, 1'b0, 22'h02400, 32'h0);
        set_port(0, 1'b0, 22'h02000, 32'h0, 3);
        set_port(2, 1'b0, 22'h02400, 32'h0, 1);
        wait_quiet("t6", 1000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
